reset_seq_sched: RTL and testbench
==================================

# reset_seq_sched

Reset-release scheduler for multiple clock/reset domains. Runs one fixed clock-enable/reset-release sequence per domain: clock gated and reset held, then clock on with reset held, then reset released. Domains are serviced one at a time under round-robin arbitration. Sits between the top-level reset source and the per-domain clock gates and reset synchronisers; every domain is sequenced automatically at power-up, and any domain can be re-sequenced later on request.

## Interface
- NUM_DOMAINS, 4: number of sequenced domains (2..16)
- PRE_CYCLES, 5: cycles with clock gated and reset asserted (1..2^CNT_W-1)
- HOLD_CYCLES, 6: cycles with clock running and reset asserted (1..2^CNT_W-1)
- POST_CYCLES, 7: settle cycles after reset release, before done (1..2^CNT_W-1)
- CNT_W, 5: phase counter width
- ID_W, max(1, clog2(NUM_DOMAINS)): domain index width

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; 0 sampled at a clk edge resets the block
- seq_en_i  in  1  1 = allowed to start new sequences; 0 = an in-progress sequence still completes
- rst_req_i  in  NUM_DOMAINS  per-domain one-cycle request pulse to re-sequence the domain
- clk_en_o  out  NUM_DOMAINS  per-domain clock enable (1 = clock running)
- rst_n_o  out  NUM_DOMAINS  per-domain reset (0 = domain held in reset)
- busy_o  out  1  1 in any state other than IDLE
- done_o  out  1  one-cycle pulse when a domain sequence completes
- done_id_o  out  ID_W  index of the completed domain; valid while done_o=1, holds its last value otherwise
- pending_o  out  NUM_DOMAINS  outstanding request mask

## Operation
- Reset values: state=IDLE, clk_en_o=0, rst_n_o=0 (all domains held), pending_o=all ones, RR pointer=0, counter=0, busy_o=0, done_o=0, done_id_o=0.
- FSM states: IDLE, GATE, CLK_ON, RELEASE, DONE.
- IDLE: if seq_en_i=1 and pending≠0, grant the first set bit at or above the RR pointer, wrapping around. At the next edge:
  - enter GATE for that domain;
  - clear its pending bit;
  - set the pointer to grant+1 mod NUM_DOMAINS;
  - clk_en_o[d]<=0, rst_n_o[d]<=0;
  - counter<=0.
- GATE: stays for PRE_CYCLES cycles. On leaving, enter CLK_ON and set clk_en_o[d]<=1.
- CLK_ON: stays for HOLD_CYCLES cycles. On leaving, enter RELEASE and set rst_n_o[d]<=1.
- RELEASE: stays for POST_CYCLES cycles, then enters DONE.
- DONE: one cycle with done_o=1 and done_id_o=d, then IDLE.
- The counter counts 0..N-1 within each phase and reloads to 0 on every phase change. It never wraps.
- Non-granted domains keep their clk_en_o/rst_n_o values unchanged.
- Requests: rst_req_i[i]=1 sets pending[i] at the next edge.
  - A request for the domain in flight is not dropped; that domain is re-sequenced after its DONE.
  - If a request and a grant clear hit the same bit at the same edge, set wins.
- seq_en_i=0 in IDLE: no grant; pending keeps accumulating.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Edge 1 is the first edge with reset=1. With defaults, power-up timing for domain 0:
  - GATE is entered at edge 1.
  - clk_en_o[0] rises after edge 1+PRE = edge 6.
  - rst_n_o[0] rises after edge 1+PRE+HOLD = edge 12.
  - DONE is entered at edge 19.
  - done_o is high between edges 19 and 20.
  - IDLE is entered at edge 20.
  - Domain 1 enters GATE at edge 21.
- Period per domain is PRE+HOLD+POST+2 cycles, which is 20 with defaults. With all pending, the power-up sequence completes in 4×20 = 80 cycles.
- Request latency: pulse at edge k sets pending at edge k. If the block is idle, GATE is entered at edge k+1.
- reset=0 mid-sequence: at the next edge all state returns to reset values, including all domains back to clk_en=0/rst_n=0 and pending=all ones. No done_o is produced.

## Test plan
- Power-up, seq_en_i=1, defaults: the bench checks the following.
  - clk_en_o[0] rises at cycle 6 and rst_n_o[0] at cycle 12.
  - done_o pulses with done_id_o=0 at cycle 19.
  - Domains 1, 2, 3 complete at cycles 39, 59, 79.
  - busy_o drops at cycle 80.
- Soft re-sequence: after power-up completes, pulse rst_req_i=4'b0100. The bench checks the following.
  - Domain 2 goes to clk_en=0/rst_n=0 one edge later.
  - The full 20-cycle sequence completes with done_id_o=2.
  - Other domains stay at 1/1 throughout.
- Round-robin: while domain 1 is in flight, pulse rst_req_i=4'b1011 → the service order is 3, 0, 1.
- Same-domain request: while domain 2 is in CLK_ON, pulse rst_req_i[2] → after done_id_o=2, domain 2 re-enters GATE at the following IDLE+1 edge.
- seq_en_i=0 at power-up: outputs stay at 0/0 and pending_o=4'b1111 for 50 cycles. After seq_en_i goes high, domain 0 enters GATE at the next edge.
- Mid-sequence reset: assert reset=0 at cycle 10 (domain 0 in CLK_ON) → at the next edge all outputs are back to reset values, with no done_o. After release the power-up sequence restarts from domain 0.

Source files
------------

// File: rtl/reset_seq_sched_if.sv
// Request/status bundle between the reset-release scheduler and its surroundings.
// master drives enables and request pulses; slave is the scheduler itself.
interface reset_seq_sched_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int ID_W        = ($clog2(NUM_DOMAINS) < 1) ? 1 : $clog2(NUM_DOMAINS)
);
  logic                   seq_en_i;
  logic [NUM_DOMAINS-1:0] rst_req_i;
  logic [NUM_DOMAINS-1:0] clk_en_o;
  logic [NUM_DOMAINS-1:0] rst_n_o;
  logic                   busy_o;
  logic                   done_o;
  logic [ID_W-1:0]        done_id_o;
  logic [NUM_DOMAINS-1:0] pending_o;

  modport master (
    output seq_en_i, rst_req_i,
    input  clk_en_o, rst_n_o, busy_o, done_o, done_id_o, pending_o
  );

  modport slave (
    input  seq_en_i, rst_req_i,
    output clk_en_o, rst_n_o, busy_o, done_o, done_id_o, pending_o
  );
endinterface

// File: rtl/reset_seq_sched.sv
// Round-robin reset-release scheduler: per domain, gate clock + hold reset, run clock
// with reset held, release reset and settle, then pulse done. All outputs registered.
module reset_seq_sched #(
  parameter int NUM_DOMAINS = 4,
  parameter int PRE_CYCLES  = 5,
  parameter int HOLD_CYCLES = 6,
  parameter int POST_CYCLES = 7,
  parameter int CNT_W       = 5,
  parameter int ID_W        = ($clog2(NUM_DOMAINS) < 1) ? 1 : $clog2(NUM_DOMAINS)
) (
  input  logic              clk,
  input  logic              reset,
  reset_seq_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GATE    = 3'd1,
    CLK_ON  = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [ID_W-1:0]        cur, cur_nxt;
  logic [ID_W-1:0]        ptr, ptr_nxt;
  logic [NUM_DOMAINS-1:0] pending, pending_nxt;
  logic [NUM_DOMAINS-1:0] clk_en, clk_en_nxt;
  logic [NUM_DOMAINS-1:0] rst_n, rst_n_nxt;
  logic                   busy, busy_nxt;
  logic                   done, done_nxt;
  logic [ID_W-1:0]        done_id, done_id_nxt;

  logic                   grant_vld;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        arb_idx;

  // Scan downward so the last hit is the one closest to (at or above) the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      arb_idx = ID_W'((int'(ptr) + i) % NUM_DOMAINS);
      if (pending[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cur     <= '0;
      ptr     <= '0;
      pending <= '1;
      clk_en  <= '0;
      rst_n   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur     <= cur_nxt;
      ptr     <= ptr_nxt;
      pending <= pending_nxt;
      clk_en  <= clk_en_nxt;
      rst_n   <= rst_n_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      done_id <= done_id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (bus.seq_en_i && grant_vld) begin
          state_nxt = GATE;
          cur_nxt   = grant_id;
          cnt_nxt   = '0;
          ptr_nxt   = (grant_id == ID_W'(NUM_DOMAINS - 1)) ? '0 : grant_id + ID_W'(1);
        end
      end
      GATE: begin
        if (cnt == CNT_W'(PRE_CYCLES - 1)) begin
          state_nxt = CLK_ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      CLK_ON: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt == CNT_W'(POST_CYCLES - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Next values of the registered outputs; new requests are OR-ed in last so set beats clear.
  always_comb begin
    pending_nxt = pending;
    clk_en_nxt  = clk_en;
    rst_n_nxt   = rst_n;
    done_id_nxt = done_id;
    if (state == IDLE && state_nxt == GATE) begin
      pending_nxt[grant_id] = 1'b0;
      clk_en_nxt[grant_id]  = 1'b0;
      rst_n_nxt[grant_id]   = 1'b0;
    end
    if (state == GATE && state_nxt == CLK_ON) begin
      clk_en_nxt[cur] = 1'b1;
    end
    if (state == CLK_ON && state_nxt == RELEASE) begin
      rst_n_nxt[cur] = 1'b1;
    end
    if (state_nxt == DONE) begin
      done_id_nxt = cur;
    end
    done_nxt    = (state_nxt == DONE);
    busy_nxt    = (state_nxt != IDLE);
    pending_nxt = pending_nxt | bus.rst_req_i;
  end

  assign bus.clk_en_o  = clk_en;
  assign bus.rst_n_o   = rst_n;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.done_id_o = done_id;
  assign bus.pending_o = pending;

endmodule

// File: tb/tb_reset_seq_sched.sv
// Directed bench for reset_seq_sched: done events are queued when stimulus is applied
// and matched (domain and edge number) whenever done_o is seen.
module tb_reset_seq_sched;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_no     = 0;

  typedef struct {
    int id;
    int at;
  } exp_t;
  exp_t sb[$];

  reset_seq_sched_if #(.NUM_DOMAINS(N), .ID_W(IW)) bus ();

  reset_seq_sched #(
    .NUM_DOMAINS(N),
    .PRE_CYCLES(5),
    .HOLD_CYCLES(6),
    .POST_CYCLES(7),
    .CNT_W(5),
    .ID_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic expect_done(input int id, input int at);
    exp_t e;
    e.id = id;
    e.at = at;
    sb.push_back(e);
  endtask

  // Advance one clock and sample on the falling edge; match any done pulse to the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    edge_no++;
    if (bus.done_o) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(bus.done_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_id", 32'(bus.done_id_o), 32'(e.id));
        chk("done_edge", 32'(edge_no), 32'(e.at));
      end
    end else if (sb.size() != 0 && edge_no > sb[0].at) begin
      chk("done_missing", 32'(bus.done_o), 32'd1);
      e = sb.pop_front();
    end
  endtask

  task automatic run_to(input int n);
    while (edge_no < n) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_clk_en"}, 32'(bus.clk_en_o), 32'h0);
    chk({tag, "_rst_n"}, 32'(bus.rst_n_o), 32'h0);
    chk({tag, "_pending"}, 32'(bus.pending_o), 32'hF);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'h0);
    chk({tag, "_done_id"}, 32'(bus.done_id_o), 32'h0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.seq_en_i  = 1'b1;
    bus.rst_req_i = '0;
    repeat (3) tick();
    check_reset_vals("rst");

    // Power-up: all four domains in order, 20 cycles each.
    reset   = 1'b1;
    edge_no = 0;
    expect_done(0, 19);
    expect_done(1, 39);
    expect_done(2, 59);
    expect_done(3, 79);
    tick();
    chk("pu_busy_e1", 32'(bus.busy_o), 32'd1);
    chk("pu_pending_e1", 32'(bus.pending_o), 32'hE);
    run_to(5);
    chk("pu_clk_en0_e5", 32'(bus.clk_en_o[0]), 32'd0);
    run_to(6);
    chk("pu_clk_en0_e6", 32'(bus.clk_en_o[0]), 32'd1);
    run_to(11);
    chk("pu_rst_n0_e11", 32'(bus.rst_n_o[0]), 32'd0);
    run_to(12);
    chk("pu_rst_n0_e12", 32'(bus.rst_n_o[0]), 32'd1);
    run_to(79);
    chk("pu_busy_e79", 32'(bus.busy_o), 32'd1);
    run_to(80);
    chk("pu_busy_e80", 32'(bus.busy_o), 32'd0);
    chk("pu_clk_en_all", 32'(bus.clk_en_o), 32'hF);
    chk("pu_rst_n_all", 32'(bus.rst_n_o), 32'hF);
    chk("pu_pending_e80", 32'(bus.pending_o), 32'h0);

    // Soft re-sequence of domain 2.
    bus.rst_req_i = 4'b0100;
    expect_done(2, 100);
    tick();
    bus.rst_req_i = '0;
    chk("soft_pending", 32'(bus.pending_o), 32'h4);
    chk("soft_clk_en_e81", 32'(bus.clk_en_o), 32'hF);
    while (edge_no < 101) begin
      tick();
      chk("soft_others_clk_en", 32'(bus.clk_en_o & 4'b1011), 32'hB);
      chk("soft_others_rst_n", 32'(bus.rst_n_o & 4'b1011), 32'hB);
      if (edge_no == 82) begin
        chk("soft_clk_en2_e82", 32'(bus.clk_en_o[2]), 32'd0);
        chk("soft_rst_n2_e82", 32'(bus.rst_n_o[2]), 32'd0);
      end
      if (edge_no == 87) chk("soft_clk_en2_e87", 32'(bus.clk_en_o[2]), 32'd1);
      if (edge_no == 92) chk("soft_rst_n2_e92", 32'(bus.rst_n_o[2]), 32'd0);
      if (edge_no == 93) chk("soft_rst_n2_e93", 32'(bus.rst_n_o[2]), 32'd1);
    end
    chk("soft_busy_e101", 32'(bus.busy_o), 32'd0);

    // Round-robin: domain 1 in flight, then 1011 requested -> order 3, 0, 1.
    bus.rst_req_i = 4'b0010;
    expect_done(1, 121);
    tick();
    bus.rst_req_i = '0;
    run_to(104);
    bus.rst_req_i = 4'b1011;
    expect_done(3, 141);
    expect_done(0, 161);
    expect_done(1, 181);
    tick();
    bus.rst_req_i = '0;
    chk("rr_pending_e105", 32'(bus.pending_o), 32'hB);
    run_to(123);
    chk("rr_clk_en3_e123", 32'(bus.clk_en_o[3]), 32'd0);
    run_to(182);
    chk("rr_busy_e182", 32'(bus.busy_o), 32'd0);
    chk("rr_pending_e182", 32'(bus.pending_o), 32'h0);

    // Same-domain request while domain 2 is in CLK_ON.
    bus.rst_req_i = 4'b0100;
    expect_done(2, 202);
    expect_done(2, 222);
    tick();
    bus.rst_req_i = '0;
    run_to(190);
    bus.rst_req_i = 4'b0100;
    tick();
    bus.rst_req_i = '0;
    chk("same_pending_e191", 32'(bus.pending_o), 32'h4);
    chk("same_clk_en2_e191", 32'(bus.clk_en_o[2]), 32'd1);
    chk("same_rst_n2_e191", 32'(bus.rst_n_o[2]), 32'd0);
    run_to(203);
    chk("same_busy_e203", 32'(bus.busy_o), 32'd0);
    chk("same_rst_n2_e203", 32'(bus.rst_n_o[2]), 32'd1);
    tick();
    chk("same_clk_en2_e204", 32'(bus.clk_en_o[2]), 32'd0);
    chk("same_rst_n2_e204", 32'(bus.rst_n_o[2]), 32'd0);
    chk("same_pending_e204", 32'(bus.pending_o), 32'h0);
    chk("same_busy_e204", 32'(bus.busy_o), 32'd1);
    run_to(223);
    chk("same_busy_e223", 32'(bus.busy_o), 32'd0);

    // Power-up with sequencing disabled for 50 cycles.
    reset = 1'b0;
    tick();
    check_reset_vals("rst2");
    bus.seq_en_i = 1'b0;
    reset        = 1'b1;
    edge_no      = 0;
    while (edge_no < 50) begin
      tick();
      chk("dis_clk_en", 32'(bus.clk_en_o), 32'h0);
      chk("dis_rst_n", 32'(bus.rst_n_o), 32'h0);
      chk("dis_pending", 32'(bus.pending_o), 32'hF);
      chk("dis_busy", 32'(bus.busy_o), 32'd0);
    end
    bus.seq_en_i = 1'b1;
    expect_done(0, 69);
    tick();
    chk("en_busy_e51", 32'(bus.busy_o), 32'd1);
    chk("en_pending_e51", 32'(bus.pending_o), 32'hE);
    run_to(56);
    chk("en_clk_en0_e56", 32'(bus.clk_en_o[0]), 32'd1);
    run_to(70);
    chk("en_busy_e70", 32'(bus.busy_o), 32'd0);

    // Mid-sequence reset with domain 0 in CLK_ON.
    reset = 1'b0;
    tick();
    check_reset_vals("rst3");
    reset   = 1'b1;
    edge_no = 0;
    expect_done(0, 19);
    run_to(10);
    chk("mid_clk_en0_e10", 32'(bus.clk_en_o[0]), 32'd1);
    chk("mid_rst_n0_e10", 32'(bus.rst_n_o[0]), 32'd0);
    reset = 1'b0;
    sb.delete();
    tick();
    check_reset_vals("mid");
    repeat (2) tick();
    chk("mid_done_held", 32'(bus.done_o), 32'd0);
    reset   = 1'b1;
    edge_no = 0;
    expect_done(0, 19);
    tick();
    chk("re_pending_e1", 32'(bus.pending_o), 32'hE);
    run_to(6);
    chk("re_clk_en_e6", 32'(bus.clk_en_o), 32'h1);
    run_to(12);
    chk("re_rst_n_e12", 32'(bus.rst_n_o), 32'h1);
    run_to(20);
    chk("re_busy_e20", 32'(bus.busy_o), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
